sys_exec: RTL and testbench

- Execute-stage sequencer for RISC-V SYSTEM-opcode instructions (opcode 7'b1110011), directly upstream of the csr block.
- Accepts one decoded SYSTEM instruction at a time and drives the csr block's op/tval/wdata/pc for exactly one cycle.
- Captures csr rdata, invalid, trap_en and trap_pc, then returns a writeback plus redirect to the pipeline over a valid/ready handshake.

---
 rtl/sys_exec_if.sv | 29 ++
 rtl/sys_exec.sv | 231 +++++++++++++++++++++++
 tb/tb_sys_exec.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_exec_if.sv
// Pipeline-facing handshake bundle for sys_exec: the instruction-in channel and the writeback/redirect-out channel.
// master = pipeline side, slave = sys_exec side.
interface sys_exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [63:0] in_rs1;

    logic        out_valid;
    logic        out_ready;
    logic        out_rd_we;
    logic [4:0]  out_rd;
    logic [63:0] out_rd_data;
    logic        out_redirect;
    logic [63:0] out_redirect_pc;

    modport master (
        output in_valid, in_inst, in_pc, in_rs1, out_ready,
        input  in_ready, out_valid, out_rd_we, out_rd, out_rd_data,
               out_redirect, out_redirect_pc
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_rs1, out_ready,
        output in_ready, out_valid, out_rd_we, out_rd, out_rd_data,
               out_redirect, out_redirect_pc
    );
endinterface

// File: rtl/sys_exec.sv
// Execute-stage sequencer for RISC-V SYSTEM instructions: issues one csr op, returns writeback + redirect.
// Latency: accept at edge N, csr_op during cycle N+1, out_valid from N+2; results held until out_ready. Optional WFI wait: SYS_WFI_EN.
`ifndef SYSOP_CSR_W
`define SYSOP_CSR_W 5'h01
`endif
`ifndef SYSOP_CSR_S
`define SYSOP_CSR_S 5'h02
`endif
`ifndef SYSOP_CSR_C
`define SYSOP_CSR_C 5'h03
`endif
`ifndef SYSOP_RET
`define SYSOP_RET   5'h04
`endif

module sys_exec #(
    parameter bit ILLEGAL_TVAL_INST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    sys_exec_if.slave   bus,
    input  logic [1:0]  cur_priv,
    input  logic        irq_pending,
    output logic [4:0]  csr_op,
    output logic [63:0] csr_tval,
    output logic [63:0] csr_wdata,
    output logic [63:0] csr_pc,
    input  logic [63:0] csr_rdata,
    input  logic        csr_invalid,
    input  logic        csr_trap_en,
    input  logic [63:0] csr_trap_pc
);
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] INST_SRET   = 32'h1020_0073;
    localparam logic [31:0] INST_WFI    = 32'h1050_0073;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic [4:0]  csr_op_q, csr_op_d;
    logic [63:0] csr_tval_q, csr_tval_d;
    logic [63:0] csr_wdata_q, csr_wdata_d;
    logic [63:0] csr_pc_q, csr_pc_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_csr_q, is_csr_d;
    logic        out_valid_q, out_valid_d;
    logic        out_rd_we_q, out_rd_we_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [63:0] out_rd_data_q, out_rd_data_d;
    logic        out_redirect_q, out_redirect_d;
    logic [63:0] out_redirect_pc_q, out_redirect_pc_d;

    logic [4:0]  dec_op;
    logic [63:0] dec_tval;
    logic [63:0] dec_wdata;
    logic        dec_is_csr;
    logic        dec_wfi;
    logic [2:0]  f3;

    assign f3      = bus.in_inst[14:12];
    assign dec_wfi = (bus.in_inst == INST_WFI);

    // Decode from the live input word; the result is registered on accept, so it reflects the latched instruction.
    always_comb begin
        dec_op     = {1'b1, 4'd2};
        dec_tval   = ILLEGAL_TVAL_INST ? {32'b0, bus.in_inst} : 64'b0;
        dec_wdata  = 64'b0;
        dec_is_csr = 1'b0;
        if (bus.in_inst[6:0] == 7'b1110011) begin
            case (f3)
                3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7: begin
                    case (f3[1:0])
                        2'd1:    dec_op = `SYSOP_CSR_W;
                        2'd2:    dec_op = `SYSOP_CSR_S;
                        default: dec_op = `SYSOP_CSR_C;
                    endcase
                    dec_tval   = {52'b0, bus.in_inst[31:20]};
                    dec_wdata  = f3[2] ? {59'b0, bus.in_inst[19:15]} : bus.in_rs1;
                    dec_is_csr = 1'b1;
                end
                3'd0: begin
                    if (bus.in_inst == INST_ECALL) begin
                        dec_op   = {1'b1, 4'd8 + {2'b0, cur_priv}};
                        dec_tval = 64'b0;
                    end else if (bus.in_inst == INST_EBREAK) begin
                        dec_op   = {1'b1, 4'd3};
                        dec_tval = bus.in_pc;
                    end else if (bus.in_inst == INST_MRET || bus.in_inst == INST_SRET) begin
                        dec_op   = `SYSOP_RET;
                        dec_tval = 64'b0;
                    end else if (dec_wfi) begin
                        dec_op   = 5'b0;
                        dec_tval = 64'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d           = state_q;
        in_ready_d        = in_ready_q;
        csr_op_d          = 5'b0;
        csr_tval_d        = 64'b0;
        csr_wdata_d       = 64'b0;
        csr_pc_d          = 64'b0;
        rd_d              = rd_q;
        is_csr_d          = is_csr_q;
        out_valid_d       = out_valid_q;
        out_rd_we_d       = out_rd_we_q;
        out_rd_d          = out_rd_q;
        out_rd_data_d     = out_rd_data_q;
        out_redirect_d    = out_redirect_q;
        out_redirect_pc_d = out_redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    in_ready_d = 1'b0;
                    rd_d       = bus.in_inst[11:7];
                    is_csr_d   = dec_is_csr;
`ifdef SYS_WFI_EN
                    if (dec_wfi) begin
                        state_d = S_WAIT;
                    end else
`endif
                    begin
                        state_d     = S_ISSUE;
                        csr_op_d    = dec_op;
                        csr_tval_d  = dec_tval;
                        csr_wdata_d = dec_wdata;
                        csr_pc_d    = bus.in_pc;
                    end
                end
            end
            S_ISSUE: begin
                state_d           = S_DONE;
                out_valid_d       = 1'b1;
                out_rd_we_d       = is_csr_q && (rd_q != 5'd0) && !csr_invalid;
                out_rd_d          = rd_q;
                out_rd_data_d     = csr_rdata;
                out_redirect_d    = csr_trap_en;
                out_redirect_pc_d = csr_trap_pc;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d           = S_IDLE;
                    in_ready_d        = 1'b1;
                    out_valid_d       = 1'b0;
                    out_rd_we_d       = 1'b0;
                    out_rd_d          = 5'd0;
                    out_rd_data_d     = 64'b0;
                    out_redirect_d    = 1'b0;
                    out_redirect_pc_d = 64'b0;
                end
            end
            default: begin
`ifdef SYS_WFI_EN
                // Wake-up completes as a plain no-op: nothing written, fetch carries on.
                if (irq_pending) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_rd_d    = rd_q;
                end
`else
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
`endif
            end
        endcase
    end

`ifndef SYS_WFI_EN
    logic unused_irq;
    assign unused_irq = irq_pending;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            in_ready_q        <= 1'b1;
            csr_op_q          <= 5'b0;
            csr_tval_q        <= 64'b0;
            csr_wdata_q       <= 64'b0;
            csr_pc_q          <= 64'b0;
            rd_q              <= 5'd0;
            is_csr_q          <= 1'b0;
            out_valid_q       <= 1'b0;
            out_rd_we_q       <= 1'b0;
            out_rd_q          <= 5'd0;
            out_rd_data_q     <= 64'b0;
            out_redirect_q    <= 1'b0;
            out_redirect_pc_q <= 64'b0;
        end else begin
            state_q           <= state_d;
            in_ready_q        <= in_ready_d;
            csr_op_q          <= csr_op_d;
            csr_tval_q        <= csr_tval_d;
            csr_wdata_q       <= csr_wdata_d;
            csr_pc_q          <= csr_pc_d;
            rd_q              <= rd_d;
            is_csr_q          <= is_csr_d;
            out_valid_q       <= out_valid_d;
            out_rd_we_q       <= out_rd_we_d;
            out_rd_q          <= out_rd_d;
            out_rd_data_q     <= out_rd_data_d;
            out_redirect_q    <= out_redirect_d;
            out_redirect_pc_q <= out_redirect_pc_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_rd_we       = out_rd_we_q;
    assign bus.out_rd          = out_rd_q;
    assign bus.out_rd_data     = out_rd_data_q;
    assign bus.out_redirect    = out_redirect_q;
    assign bus.out_redirect_pc = out_redirect_pc_q;
    assign csr_op              = csr_op_q;
    assign csr_tval            = csr_tval_q;
    assign csr_wdata           = csr_wdata_q;
    assign csr_pc              = csr_pc_q;
endmodule

// File: tb/tb_sys_exec.sv
// Directed bench for sys_exec: emulates the csr block and the pipeline, scoreboards writeback/redirect results.
module tb_sys_exec;
    localparam logic [4:0] OP_W   = 5'h01;
    localparam logic [4:0] OP_S   = 5'h02;
    localparam logic [4:0] OP_C   = 5'h03;
    localparam logic [4:0] OP_RET = 5'h04;

    typedef struct packed {
        logic        rd_we;
        logic [4:0]  rd;
        logic [63:0] rd_data;
        logic        redirect;
        logic [63:0] redirect_pc;
    } res_t;

    logic        clk;
    logic        rst;
    logic [1:0]  cur_priv;
    logic        irq_pending;
    logic [4:0]  csr_op;
    logic [63:0] csr_tval, csr_wdata, csr_pc;
    logic [63:0] csr_rdata;
    logic        csr_invalid, csr_trap_en;
    logic [63:0] csr_trap_pc;

    sys_exec_if bus ();

    sys_exec #(.ILLEGAL_TVAL_INST(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cur_priv(cur_priv), .irq_pending(irq_pending),
        .csr_op(csr_op), .csr_tval(csr_tval), .csr_wdata(csr_wdata), .csr_pc(csr_pc),
        .csr_rdata(csr_rdata), .csr_invalid(csr_invalid),
        .csr_trap_en(csr_trap_en), .csr_trap_pc(csr_trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_csr(input logic [11:0] csr, input logic [4:0] src,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {csr, src, f3, rd, 7'b1110011};
    endfunction

    task automatic push_exp(input logic rd_we, input logic [4:0] rd, input logic [63:0] rd_data,
                            input logic redirect, input logic [63:0] redirect_pc);
        res_t r;
        r.rd_we = rd_we; r.rd = rd; r.rd_data = rd_data;
        r.redirect = redirect; r.redirect_pc = redirect_pc;
        sb_q.push_back(r);
    endtask

    task automatic pop_cmp(input string tag);
        res_t r;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            r = sb_q.pop_front();
            chk({tag, "_rd_we"}, bus.out_rd_we, r.rd_we);
            chk({tag, "_rd"}, bus.out_rd, r.rd);
            chk({tag, "_rd_data"}, bus.out_rd_data, r.rd_data);
            chk({tag, "_redirect"}, bus.out_redirect, r.redirect);
            chk({tag, "_redirect_pc"}, bus.out_redirect_pc, r.redirect_pc);
        end
    endtask

    // Bounded wait for a result; an expired bound is reported as a failed comparison.
    task automatic wait_out(input string tag);
        for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b1);
    endtask

    // Called on a negedge with the DUT in IDLE; returns on a negedge with the DUT back in IDLE.
    task automatic run(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] rs1, input logic [1:0] priv,
                       input logic [4:0] e_op, input logic [63:0] e_tval, input logic [63:0] e_wdata,
                       input logic [63:0] rdata, input logic inval, input logic trap_en,
                       input logic [63:0] trap_pc, input logic e_rd_we, input int hold);
        logic [63:0] held_data, held_pc;
        chk({tag, "_in_ready_idle"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_pc = pc; bus.in_rs1 = rs1; cur_priv = priv;
        push_exp(e_rd_we, inst[11:7], rdata, trap_en, trap_pc);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_inst = 32'hFFFF_FFFF; bus.in_pc = '1; bus.in_rs1 = '1; cur_priv = 2'd2;
        chk({tag, "_op"}, csr_op, e_op);
        chk({tag, "_tval"}, csr_tval, e_tval);
        chk({tag, "_wdata"}, csr_wdata, e_wdata);
        chk({tag, "_pc"}, csr_pc, pc);
        chk({tag, "_in_ready_issue"}, bus.in_ready, 1'b0);
        chk({tag, "_no_early_valid"}, bus.out_valid, 1'b0);
        csr_rdata = rdata; csr_invalid = inval; csr_trap_en = trap_en; csr_trap_pc = trap_pc;
        @(negedge clk);
        csr_rdata = 64'hDEAD; csr_invalid = 1'b0; csr_trap_en = 1'b0; csr_trap_pc = 64'h0;
        chk({tag, "_op_one_cycle"}, csr_op, 5'd0);
        wait_out(tag);
        held_data = bus.out_rd_data; held_pc = bus.out_redirect_pc;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_valid"}, bus.out_valid, 1'b1);
            chk({tag, "_hold_in_ready"}, bus.in_ready, 1'b0);
            chk({tag, "_hold_data"}, bus.out_rd_data, held_data);
            chk({tag, "_hold_pc"}, bus.out_redirect_pc, held_pc);
            chk({tag, "_hold_op"}, csr_op, 5'd0);
        end
        bus.in_valid = 1'b0;
        pop_cmp(tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, bus.out_valid, 1'b0);
        chk({tag, "_ready_back"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; cur_priv = 2'd3; irq_pending = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = 32'h0; bus.in_pc = 64'h0; bus.in_rs1 = 64'h0;
        bus.out_ready = 1'b0;
        csr_rdata = 64'h0; csr_invalid = 1'b0; csr_trap_en = 1'b0; csr_trap_pc = 64'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_csr_op", csr_op, 5'd0);
        chk("rst_rd_data", bus.out_rd_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run("csrrw", mk_csr(12'h305, 5'd10, 3'd1, 5'd5), 64'h100, 64'h8000_0000, 2'd3,
            OP_W, 64'h305, 64'h8000_0000, 64'h1234, 1'b0, 1'b0, 64'h0, 1'b1, 0);
        run("csrrsi_x0", mk_csr(12'h300, 5'd0, 3'd6, 5'd0), 64'h104, 64'hFFFF, 2'd3,
            OP_S, 64'h300, 64'h0, 64'h55, 1'b0, 1'b0, 64'h0, 1'b0, 0);
        run("csrrci", mk_csr(12'h340, 5'h1F, 3'd7, 5'd3), 64'h108, 64'h77, 2'd1,
            OP_C, 64'h340, 64'h1F, 64'hABCD, 1'b0, 1'b0, 64'h0, 1'b1, 0);
        run("csrrs_zero", mk_csr(12'h341, 5'd1, 3'd2, 5'd6), 64'h10C, 64'h0, 2'd3,
            OP_S, 64'h341, 64'h0, 64'h9, 1'b0, 1'b0, 64'h0, 1'b1, 0);
        run("ecall_u", 32'h0000_0073, 64'h1000, 64'h0, 2'd0,
            5'h18, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 0);
        run("ecall_m", 32'h0000_0073, 64'h1010, 64'h0, 2'd3,
            5'h1B, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 0);
        run("ebreak", 32'h0010_0073, 64'h3000, 64'h0, 2'd3,
            5'h13, 64'h3000, 64'h0, 64'h0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 0);
        run("mret", 32'h3020_0073, 64'h4000, 64'h0, 2'd3,
            OP_RET, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h4444, 1'b0, 0);
        run("satp_inval", mk_csr(12'h180, 5'd2, 3'd1, 5'd7), 64'h5000, 64'h1, 2'd1,
            OP_W, 64'h180, 64'h1, 64'h0, 1'b1, 1'b1, 64'h5004, 1'b0, 0);
        run("illegal_hold", 32'h0020_0073, 64'h2000, 64'h0, 2'd3,
            5'h12, 64'h0020_0073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 5);

        // Reset in the middle of an instruction: it is dropped without a result.
        bus.in_valid = 1'b1; bus.in_inst = mk_csr(12'h305, 5'd4, 3'd1, 5'd9);
        bus.in_pc = 64'h6000; bus.in_rs1 = 64'h42;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("abort_issue_op", csr_op, OP_W);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_csr_op", csr_op, 5'd0);
        chk("abort_csr_tval", csr_tval, 64'd0);
        chk("abort_csr_pc", csr_pc, 64'd0);
        @(negedge clk);
        chk("abort_no_result", bus.out_valid, 1'b0);

`ifdef SYS_WFI_EN
        bus.in_valid = 1'b1; bus.in_inst = 32'h1050_0073; bus.in_pc = 64'h7000; irq_pending = 1'b0;
        push_exp(1'b0, 5'd0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("wfi_no_op", csr_op, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wfi_waiting", bus.out_valid, 1'b0);
        end
        irq_pending = 1'b1;
        @(negedge clk);
        irq_pending = 1'b0;
        wait_out("wfi");
        pop_cmp("wfi");
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("wfi_ready_back", bus.in_ready, 1'b1);
`else
        irq_pending = 1'b1;
        run("wfi_nop", 32'h1050_0073, 64'h7000, 64'h0, 2'd3,
            5'h00, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 0);
        irq_pending = 1'b0;
`endif
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
